// File: rtl/fetch_queue_pkg.sv
// Shared types for the fetch-to-decode packet queue.
// Field widths match the fetch_queue default parameters.
package fetchPkg;

    localparam int FQ_DEPTH = 8;
    localparam int FQ_WIDTH = 31;
    localparam int FQ_INDEX = 7;

    typedef struct packed {
        logic [FQ_WIDTH:0] instr;
        logic [FQ_WIDTH:0] pc;
        logic [FQ_WIDTH:0] predictedPC;
        logic [FQ_INDEX:0] GHRIndex;
        logic [1:0]        PHTState;
        logic              redirect;
    } fetchPacket_t;

endpackage

// File: rtl/fetch_queue_mem.sv
// Packet storage: one synchronous write port, one asynchronous read port.
// Contents are not reset; validity is tracked by the queue count.
import fetchPkg::*;

module fetch_queue_mem #(
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  fetchPacket_t  i_wdata,
    input  logic [AW-1:0] i_raddr,
    output fetchPacket_t  o_rdata
);

    fetchPacket_t r_mem [2**AW];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fetch_queue.sv
// Eight-entry in-order queue between fetch and decode.
// Flush empties it in one cycle; full/empty come from the count only.
import fetchPkg::*;

module fetch_queue #(
    parameter int WIDTH    = 31,
    parameter int INDEX    = 7,
    parameter int Q        = 2,
    parameter int AF_LEVEL = 6
) (
    input  logic             clk,
    input  logic             globalReset,
    input  logic             flush,
    input  logic             fetchValid,
    input  logic [WIDTH:0]   instr,
    input  logic [WIDTH:0]   instrPC,
    input  logic [WIDTH:0]   predictedPCF,
    input  logic [INDEX:0]   GHRIndex,
    input  logic [1:0]       PHTState,
    input  logic             redirect,
    output logic             freeze,
    output logic             almostFull,
    input  logic             decodeReady,
    output logic             outValid,
    output logic [WIDTH:0]   outInstr,
    output logic [WIDTH:0]   outPC,
    output logic [WIDTH:0]   outPredictPC,
    output logic [INDEX:0]   outGHRIndex,
    output logic [1:0]       outPHTState,
    output logic             outRedirect,
    output logic [Q+1:0]     count
);

    logic [Q:0]    r_wrPtr;
    logic [Q:0]    r_rdPtr;
    logic [Q+1:0]  r_count;
    logic          w_push;
    logic          w_pop;
    fetchPacket_t  w_wrPkt;
    fetchPacket_t  w_rdPkt;

    assign freeze     = (r_count == (Q+2)'(FQ_DEPTH));
    assign outValid   = (r_count != '0);
    assign almostFull = (r_count >= (Q+2)'(AF_LEVEL));
    assign count      = r_count;

    assign w_push = fetchValid & ~freeze & ~flush;
    assign w_pop  = decodeReady & outValid & ~flush;

    always_comb begin
        w_wrPkt             = '0;
        w_wrPkt.instr       = instr;
        w_wrPkt.pc          = instrPC;
        w_wrPkt.predictedPC = predictedPCF;
        w_wrPkt.GHRIndex    = GHRIndex;
        w_wrPkt.PHTState    = PHTState;
        w_wrPkt.redirect    = redirect;
    end

    fetch_queue_mem #(
        .AW (Q+1)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_push),
        .i_waddr (r_wrPtr),
        .i_wdata (w_wrPkt),
        .i_raddr (r_rdPtr),
        .o_rdata (w_rdPkt)
    );

    // Flush wins over any push or pop in the same cycle.
    always_ff @(posedge clk or negedge globalReset) begin
        if (!globalReset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Stale storage is masked so an empty queue shows all-zero fields.
    assign outInstr     = outValid ? w_rdPkt.instr       : '0;
    assign outPC        = outValid ? w_rdPkt.pc          : '0;
    assign outPredictPC = outValid ? w_rdPkt.predictedPC : '0;
    assign outGHRIndex  = outValid ? w_rdPkt.GHRIndex    : '0;
    assign outPHTState  = outValid ? w_rdPkt.PHTState    : '0;
    assign outRedirect  = outValid ? w_rdPkt.redirect    : 1'b0;

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Eight-entry in-order FIFO between `instrFetchUnit` and `instr_decode`. Each entry holds one fetch packet: instruction word, its PC, the predicted next PC, and the gshare snapshot (GHR index, PHT state, redirect flag). It decouples fetch from decode stalls caused by a full ROB or full reservation stations. It is emptied in one cycle on a control-flow recovery.

## Interface
Parameters:
- WIDTH, 31, MSB index of instruction/PC fields
- INDEX, 7, MSB index of GHR index field
- Q, 2, MSB index of read/write pointers; depth = 2^(Q+1) = 8
- AF_LEVEL, 6, occupancy at or above which `almostFull` asserts

Ports:
- clk  in  1  clock, rising edge
- globalReset  in  1  reset, asynchronous, active-low
- flush  in  1  recovery (ROB mispredict or rename-stage JAL redirect); discards all entries
- fetchValid  in  1  fetch presents a packet this cycle
- instr  in  WIDTH+1  instruction word
- instrPC  in  WIDTH+1  PC of `instr`
- predictedPCF  in  WIDTH+1  predicted next PC
- GHRIndex  in  INDEX+1  gshare index used for prediction
- PHTState  in  2  PHT counter read
- redirect  in  1  predictor redirected flow
- freeze  out  1  queue full; fetch must hold its PC
- almostFull  out  1  count ≥ AF_LEVEL
- decodeReady  in  1  decode consumes the head packet this cycle
- outValid  out  1  head packet valid
- outInstr, outPC, outPredictPC  out  WIDTH+1  head fields
- outGHRIndex  out  INDEX+1  head field
- outPHTState  out  2  head field
- outRedirect  out  1  head field
- count  out  Q+2  occupancy, 0..8

## Operation
- push = fetchValid & !freeze & !flush. The packet is written at `wrPtr`, and `wrPtr` increments modulo 8.
- pop = decodeReady & outValid & !flush. `rdPtr` increments modulo 8.
- count_next = count + push − pop. A simultaneous push and pop leaves count unchanged.
- freeze = (count == 8). outValid = (count != 0). Both are decoded from registered count only; there is no combinational path from input to output.
- Head outputs show `mem[rdPtr]` when outValid. When empty, all data outputs are 0.
- Flush has priority over push and pop in the same cycle. Next state: rdPtr = wrPtr = 0, count = 0. The packet presented by fetch in the flush cycle is dropped.
- A push while full is ignored. Fetch is responsible for holding its packet.
- decodeReady while empty has no effect.
- Pointer wrap: 7 → 0 with no gap. Full and empty are distinguished by count, not by pointer equality.
- Reset (globalReset low, asynchronous): pointers = 0, count = 0, freeze = 0, almostFull = 0, outValid = 0, all data outputs = 0. Storage contents are don't-care.
- Reset asserted mid-operation discards all contents immediately, without waiting for a clock edge.

## Timing
- Write latency is 1 cycle. A packet pushed at edge N is visible at the head after edge N, provided the queue was empty. There is no same-cycle bypass.
- Pop takes effect at the edge. The next entry appears at the head in the following cycle.
- Sustained throughput is one push and one pop per cycle.
- freeze rises in the cycle after the 8th push. It falls in the cycle after the first pop from full.
- After flush: outValid = 0 for at least one cycle. The first post-flush fetch packet reaches the head 1 cycle after it is pushed.

## Structure
- Shared package `fetchPkg`:
  - `fetchPacket_t` packed struct {instr, pc, predictedPC, GHRIndex, PHTState, redirect}
  - `FQ_DEPTH = 8`
- Sub-module `fetch_queue_mem`: 8 × `fetchPacket_t` register array with one write port and one asynchronous read port.
- Pointer, count and flag logic live in `fetch_queue`.

## Test plan
- Reset: hold globalReset low, drive fetchValid = 1 → outValid = 0, count = 0, freeze = 0, all data outputs 0.
- In-order fill and drain: push instrPC 0x00..0x1C (step 4) with decodeReady = 0 → freeze = 1 after the 8th push and count = 8. Then set decodeReady = 1 → outPC appears as 0x00, 0x04, … 0x1C on consecutive cycles, with outValid falling after the last.
- Push while full: with count = 8, drive fetchValid = 1 with instrPC 0x40 for 3 cycles → count stays 8. After draining, 0x40 never appears.
- Simultaneous push/pop: at count = 3, push 0x100 and pop together for 10 cycles → count stays 3 and pointers wrap. Output order matches input order.
- Flush priority: at count = 5, assert flush together with fetchValid (PC 0x200) and decodeReady → the next cycle has count = 0 and outValid = 0, and 0x200 is never output. A push of 0x300 in the next cycle is at the head one cycle later.
- Async reset mid-stream: at count = 4, pull globalReset low between clock edges → outputs clear without a clock edge. After release, the first push of 0x500 is the head.
